// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pkg
//  Description : Shared types and helpers for the TDC readout controller:
//                FSM state encoding, fine-code width helper, default settle.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    // Readout FSM states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_COUNT      = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_CAPTURE    = 3'd5,
        ST_DECODE     = 3'd6,
        ST_OUTPUT     = 3'd7
    } tdc_state_e;

    // Default number of cycles the delay line is left to settle after stop
    localparam int c_default_settle_cyc = 2;

    // Width of the fine code for a given tap count (never below one bit)
    function automatic int fine_w(input int num_taps);
        return (num_taps <= 2) ? 1 : $clog2(num_taps);
    endfunction

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_therm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_therm_decode
//  Description : Combinational thermometer decoder. Removes single-tap
//                bubbles with a 3-input majority vote and counts the
//                corrected ones, saturating at NUM_TAPS-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS = 32
) (
    input  logic [NUM_TAPS-1:0]          i_taps,
    output logic [fine_w(NUM_TAPS)-1:0]  o_fine
);

    localparam int c_FW = fine_w(NUM_TAPS);
    // Counter wide enough to hold NUM_TAPS itself before saturation
    localparam int c_CW = $clog2(NUM_TAPS + 1);

    // Taps padded with the virtual neighbours: a 1 below tap 0, a 0 above the last tap
    logic [NUM_TAPS+1:0] w_ext;
    logic [NUM_TAPS-1:0] w_corr;
    logic [c_CW-1:0]     w_count;

    assign w_ext = {1'b0, i_taps, 1'b1};

    // Majority of each tap and its two neighbours (w_ext index is tap index + 1)
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_corr
        assign w_corr[gi] = (w_ext[gi]   & w_ext[gi+1])
                          | (w_ext[gi+1] & w_ext[gi+2])
                          | (w_ext[gi]   & w_ext[gi+2]);
    end

    // Population count of the corrected taps, then clamp to the largest fine code
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_count = w_count + c_CW'(w_corr[i]);
        end
        if (w_count > c_CW'(NUM_TAPS - 1)) begin
            o_fine = c_FW'(NUM_TAPS - 1);
        end else begin
            o_fine = w_count[c_FW-1:0];
        end
    end

endmodule : tdc_therm_decode
`default_nettype wire

// File: rtl/tdc_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_readout
//  Description : Readout controller for the tdc_top delay line. Arms and
//                clears the front end, synchronises the start/stop hit
//                flags, counts coarse clock cycles between them, samples and
//                decodes the thermometer taps after settling, and presents
//                each measurement once on a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS   = 32,
    parameter int COARSE_W   = 16,
    parameter int SETTLE_CYC = c_default_settle_cyc
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic                          start_flag,
    input  logic                          stop_flag,
    input  logic [NUM_TAPS-1:0]           taps_raw,
    output logic                          tdc_clear,
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [COARSE_W-1:0]           res_coarse,
    output logic [fine_w(NUM_TAPS)-1:0]   res_fine,
    output logic                          res_timeout
);

    localparam int                c_FW          = fine_w(NUM_TAPS);
    localparam int                c_SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [COARSE_W-1:0] c_COARSE_MAX = '1;
    localparam logic [c_SW-1:0]   c_SETTLE_LAST = c_SW'(SETTLE_CYC - 1);

    // Synchroniser stages for the asynchronous hit flags
    logic                r_start_meta;
    logic                r_start_s;
    logic                r_stop_meta;
    logic                r_stop_s;

    // Controller state and datapath registers
    tdc_state_e          r_state;
    logic [COARSE_W-1:0] r_coarse;
    logic [c_SW-1:0]     r_settle_cnt;
    logic [NUM_TAPS-1:0] r_taps;
    logic [c_FW-1:0]     r_res_fine;
    logic                r_res_timeout;

    // Next-state values
    tdc_state_e          w_state_nxt;
    logic [COARSE_W-1:0] w_coarse_nxt;
    logic [COARSE_W-1:0] w_coarse_inc;
    logic [c_SW-1:0]     w_settle_nxt;
    logic [NUM_TAPS-1:0] w_taps_nxt;
    logic [c_FW-1:0]     w_res_fine_nxt;
    logic                w_res_timeout_nxt;
    logic [c_FW-1:0]     w_fine_dec;

    // Bubble-corrected fine code of the captured taps
    tdc_therm_decode #(
        .NUM_TAPS (NUM_TAPS)
    ) u_decode (
        .i_taps (r_taps),
        .o_fine (w_fine_dec)
    );

    // Two-flop synchronisers for the start and stop hit flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_meta <= 1'b0;
            r_start_s    <= 1'b0;
            r_stop_meta  <= 1'b0;
            r_stop_s     <= 1'b0;
        end else begin
            r_start_meta <= start_flag;
            r_start_s    <= r_start_meta;
            r_stop_meta  <= stop_flag;
            r_stop_s     <= r_stop_meta;
        end
    end

    // State and datapath registers, all cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_coarse      <= '0;
            r_settle_cnt  <= '0;
            r_taps        <= '0;
            r_res_fine    <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_coarse      <= w_coarse_nxt;
            r_settle_cnt  <= w_settle_nxt;
            r_taps        <= w_taps_nxt;
            r_res_fine    <= w_res_fine_nxt;
            r_res_timeout <= w_res_timeout_nxt;
        end
    end

    // Saturating coarse increment; the timeout exit normally stops it first
    assign w_coarse_inc = (r_coarse == c_COARSE_MAX) ? r_coarse : r_coarse + COARSE_W'(1);

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_coarse_nxt      = r_coarse;
        w_settle_nxt      = r_settle_cnt;
        w_taps_nxt        = r_taps;
        w_res_fine_nxt    = r_res_fine;
        w_res_timeout_nxt = r_res_timeout;
        tdc_clear         = 1'b0;
        busy              = (r_state != ST_IDLE);
        res_valid         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_state_nxt = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                tdc_clear         = 1'b1;
                w_coarse_nxt      = '0;
                w_res_fine_nxt    = '0;
                w_res_timeout_nxt = 1'b0;
                w_state_nxt       = ST_WAIT_START;
            end

            ST_WAIT_START: begin
                // A stop that arrives without a start is ignored; both
                // together mean a zero-length coarse interval.
                if (r_start_s && r_stop_s) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = ST_SETTLE;
                end else if (r_start_s) begin
                    w_state_nxt = ST_COUNT;
                end
            end

            ST_COUNT: begin
                // The stop cycle itself is still counted
                w_coarse_nxt = w_coarse_inc;
                if (r_stop_s) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = ST_SETTLE;
                end else if (w_coarse_inc == c_COARSE_MAX) begin
                    w_res_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_OUTPUT;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_settle_nxt = r_settle_cnt + c_SW'(1);
                end
            end

            ST_CAPTURE: begin
                w_taps_nxt  = taps_raw;
                w_state_nxt = ST_DECODE;
            end

            ST_DECODE: begin
                w_res_fine_nxt = w_fine_dec;
                w_state_nxt    = ST_OUTPUT;
            end

            ST_OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign res_coarse  = r_coarse;
    assign res_fine    = r_res_fine;
    assign res_timeout = r_res_timeout;

endmodule : tdc_readout
`default_nettype wire

// File: tb/tb_tdc_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_readout
//  Description : Self-checking bench for tdc_readout. Directed measurements
//                with literal expectations, plus a result scoreboard filled
//                from a behavioural model and checked every output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_readout;

    localparam int c_NUM_TAPS   = 32;
    localparam int c_COARSE_W   = 4;
    localparam int c_SETTLE     = 2;
    localparam int c_COARSE_MAX = (1 << c_COARSE_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        start_flag;
    logic        stop_flag;
    logic [31:0] taps_raw;
    logic        tdc_clear;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_coarse;
    logic [4:0]  res_fine;
    logic        res_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_clear = 0;

    int exp_coarse_q[$];
    int exp_fine_q[$];
    int exp_to_q[$];

    tdc_readout #(
        .NUM_TAPS   (c_NUM_TAPS),
        .COARSE_W   (c_COARSE_W),
        .SETTLE_CYC (c_SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm         (arm),
        .start_flag  (start_flag),
        .stop_flag   (stop_flag),
        .taps_raw    (taps_raw),
        .tdc_clear   (tdc_clear),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_coarse  (res_coarse),
        .res_fine    (res_fine),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Fine code from the rules: majority of neighbours with a virtual 1 below
    // tap 0 and a virtual 0 above the top tap, count the ones, clamp to 31.
    function automatic int fine_model(input logic [31:0] t);
        int cnt;
        int l;
        int r;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            l = (i == 0)  ? 1 : int'(t[(i + 31) % 32]);
            r = (i == 31) ? 0 : int'(t[(i + 1) % 32]);
            if (l + int'(t[i]) + r >= 2) cnt++;
        end
        return (cnt > 31) ? 31 : cnt;
    endfunction

    // Scoreboard compare: every cycle a result is offered it must match the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tdc_clear) n_clear++;
            if (res_valid) begin
                if (exp_coarse_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    check("sb_coarse", res_coarse, exp_coarse_q[0]);
                    check("sb_fine", res_fine, exp_fine_q[0]);
                    check("sb_timeout", res_timeout, exp_to_q[0]);
                    check("sb_busy", busy, 1);
                    if (res_ready) begin
                        void'(exp_coarse_q.pop_front());
                        void'(exp_fine_q.pop_front());
                        void'(exp_to_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!res_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!res_valid) check({name, "_valid_never_rose"}, 0, 1);
    endtask

    // sep >= 0: stop raised sep cycles after start (0 = same cycle)
    // sep <  0: stop raised first, start -sep cycles later
    // lat is counted in clocks from raising the last flag to res_valid
    task automatic run_meas(input string name, input logic [31:0] taps, input int sep,
                            input bit no_stop, input bit backpressure,
                            input int exp_coarse, input int exp_fine,
                            input int exp_to, input int exp_lat);
        int clr0;
        int lat;
        int m_coarse;
        taps_raw  = taps;
        res_ready = !backpressure;
        clr0      = n_clear;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check({name, "_clear_pulse"}, tdc_clear, 1);
        check({name, "_busy_armed"}, busy, 1);
        tick();
        check({name, "_clear_single"}, tdc_clear, 0);

        if (no_stop) begin
            exp_coarse_q.push_back(c_COARSE_MAX);
            exp_fine_q.push_back(0);
            exp_to_q.push_back(1);
        end else begin
            m_coarse = (sep > 0) ? sep : 0;
            if (m_coarse > c_COARSE_MAX) m_coarse = c_COARSE_MAX;
            exp_coarse_q.push_back(m_coarse);
            exp_fine_q.push_back(fine_model(taps));
            exp_to_q.push_back(0);
        end

        if (sep < 0) begin
            stop_flag = 1'b1;
            repeat (-sep) tick();
            start_flag = 1'b1;
        end else begin
            start_flag = 1'b1;
            if (!no_stop) begin
                repeat (sep) tick();
                stop_flag = 1'b1;
            end
        end

        wait_valid(name, lat);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_coarse"}, res_coarse, exp_coarse);
        check({name, "_fine"}, res_fine, exp_fine);
        check({name, "_timeout"}, res_timeout, exp_to);

        if (backpressure) begin
            for (int k = 0; k < 10; k++) begin
                arm = 1'b1;
                tick();
                check({name, "_bp_valid_held"}, res_valid, 1);
                check({name, "_bp_coarse_held"}, res_coarse, exp_coarse);
                check({name, "_bp_fine_held"}, res_fine, exp_fine);
            end
            arm = 1'b0;
            res_ready = 1'b1;
        end

        tick();
        check({name, "_valid_dropped"}, res_valid, 0);
        check({name, "_busy_dropped"}, busy, 0);
        check({name, "_clear_count"}, n_clear - clr0, 1);
        start_flag = 1'b0;
        stop_flag  = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        arm        = 1'b0;
        start_flag = 1'b0;
        stop_flag  = 1'b0;
        taps_raw   = '0;
        res_ready  = 1'b1;

        repeat (3) tick();
        check("rst_tdc_clear", tdc_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_coarse", res_coarse, 0);
        check("rst_res_fine", res_fine, 0);
        check("rst_res_timeout", res_timeout, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // name, taps, sep, no_stop, bp, coarse, fine, timeout, latency
        run_meas("normal",     32'h0000_FFFF,  6, 1'b0, 1'b0,  6, 16, 0,  7);
        run_meas("bubble8",    32'h0000_FEFF,  4, 1'b0, 1'b0,  4, 16, 0,  7);
        run_meas("isolated16", 32'h0001_0FFF,  9, 1'b0, 1'b0,  9, 12, 0,  7);
        run_meas("all_zero",   32'h0000_0000,  2, 1'b0, 1'b0,  2,  0, 0,  7);
        run_meas("all_ones",   32'hFFFF_FFFF,  1, 1'b0, 1'b0,  1, 31, 0,  7);
        run_meas("same_cycle", 32'h0000_00FF,  0, 1'b0, 1'b0,  0,  8, 0,  7);
        run_meas("stop_first", 32'h0000_000F, -3, 1'b0, 1'b0,  0,  4, 0,  7);
        run_meas("timeout",    32'h0000_FFFF,  0, 1'b1, 1'b0, 15,  0, 1, 18);
        run_meas("near_max",   32'h0000_0003, 14, 1'b0, 1'b0, 14,  2, 0,  7);
        run_meas("stop_at_max",32'h0000_003F, 15, 1'b0, 1'b0, 15,  6, 0,  7);
        run_meas("backpress",  32'h0000_0FFF,  3, 1'b0, 1'b1,  3, 12, 0,  7);

        // Reset in the middle of counting aborts the measurement
        taps_raw = 32'h0000_FFFF;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        start_flag = 1'b1;
        repeat (8) tick();
        check("midrst_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_coarse", res_coarse, 0);
        check("midrst_fine", res_fine, 0);
        check("midrst_timeout", res_timeout, 0);
        check("midrst_clear", tdc_clear, 0);
        start_flag = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("midrst_idle_after", busy, 0);
        run_meas("after_reset", 32'h0000_FFFF, 5, 1'b0, 1'b0, 5, 16, 0, 7);

        check("sb_drained", exp_coarse_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule : tb_tdc_readout
`default_nettype wire
